noc0_tx_msg_arbiter: RTL



---
 rtl/noc_arb_pkg.sv | 19 +
 rtl/noc0_tx_msg_arbiter_rr_pick.sv | 37 +++
 rtl/noc0_tx_msg_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/noc_arb_pkg.sv
// Shared definitions for noc0 tile arbiters: FSM states and the header
// length-field position that producers and arbiters must agree on.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

package noc_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_HDR,
      ARB_BODY
   } arb_state_e;

   // Header flit carries the payload flit count in [NOC_LEN_LSB +: NOC_LEN_W]
   localparam int NOC_LEN_LSB = 0;
   localparam int NOC_LEN_W   = 8;

endpackage

// File: rtl/noc0_tx_msg_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// scanning cyclically. Reusable by other tile arbiters.
module rr_pick #(
   parameter int NUM_SRC = 2,
   parameter int IDX_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] grant_oh,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any       = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int off = 0; off < NUM_SRC; off++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(off);
         if (sum >= (IDX_W+1)'(NUM_SRC)) begin
            sum = sum - (IDX_W+1)'(NUM_SRC);
         end
         idx = sum[IDX_W-1:0];
         if (!any && req[idx]) begin
            any           = 1'b1;
            grant_idx     = idx;
            grant_oh[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc0_tx_msg_arbiter.sv
// Message-granular round-robin arbiter sharing one noc0 val/rdy injection
// port between NUM_SRC producers; data and handshake pass through combinationally.
//
//   state    | meaning
//   ARB_IDLE | no owner; grant chosen combinationally by round-robin scan
//   ARB_HDR  | owner latched, its header flit not yet accepted
//   ARB_BODY | header accepted; remain_r payload flits still to go
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

module noc0_tx_msg_arbiter
   import noc_arb_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int DATA_W  = `NOC_DATA_WIDTH,
   parameter int LEN_LSB = NOC_LEN_LSB,
   parameter int LEN_W   = NOC_LEN_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC-1:0]        src_arb_val,
   input  logic [NUM_SRC*DATA_W-1:0] src_arb_data,
   output logic [NUM_SRC-1:0]        arb_src_rdy,
   output logic                      arb_dst_val,
   output logic [DATA_W-1:0]         arb_dst_data,
   input  logic                      dst_arb_rdy,
   output logic [NUM_SRC-1:0]        arb_grant_oh,
   output logic                      arb_msg_done
);

   localparam int               IDX_W    = $clog2(NUM_SRC);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

   arb_state_e       state_r, state_nxt;
   logic [IDX_W-1:0] prio_ptr_r, prio_ptr_nxt;
   logic [IDX_W-1:0] owner_r, owner_nxt;
   logic [LEN_W-1:0] remain_r, remain_nxt;

   logic [NUM_SRC-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;

   logic [DATA_W-1:0] src_data_a [NUM_SRC];
   logic [IDX_W-1:0]  g;
   logic [IDX_W-1:0]  g_succ;
   logic              g_valid;
   logic              hs;
   logic [LEN_W-1:0]  hdr_len;
   logic              last_flit;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign src_data_a[i] = src_arb_data[i*DATA_W +: DATA_W];
   end

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req       (src_arb_val),
      .ptr       (prio_ptr_r),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

   // Grant/forwarding path; everything is forced to 0 while rst_n is low
   always_comb begin
      g            = (state_r == ARB_IDLE) ? pick_idx : owner_r;
      g_valid      = rst_n && ((state_r != ARB_IDLE) || pick_any);
      g_succ       = (g == LAST_IDX) ? '0 : g + IDX_W'(1);
      arb_dst_val  = g_valid && src_arb_val[g];
      arb_dst_data = g_valid ? src_data_a[g] : '0;
      arb_src_rdy  = g_valid ? (NUM_SRC'(dst_arb_rdy) << g) : '0;
      arb_grant_oh = '0;
      if (g_valid) begin
         arb_grant_oh = (state_r == ARB_IDLE) ? pick_oh : (NUM_SRC'(1) << owner_r);
      end
      hs           = arb_dst_val && dst_arb_rdy;
      hdr_len      = src_data_a[g][LEN_LSB +: LEN_W];
      last_flit    = (state_r == ARB_BODY) ? (remain_r == LEN_W'(1)) : (hdr_len == '0);
      arb_msg_done = hs && last_flit;
   end

   always_comb begin
      state_nxt    = state_r;
      prio_ptr_nxt = prio_ptr_r;
      owner_nxt    = owner_r;
      remain_nxt   = remain_r;
      case (state_r)
         ARB_IDLE: begin
            if (pick_any) begin
               if (!hs) begin
                  // Lock the owner so a stalled header cannot lose its grant
                  owner_nxt = pick_idx;
                  state_nxt = ARB_HDR;
               end else if (hdr_len == '0) begin
                  prio_ptr_nxt = g_succ;
               end else begin
                  owner_nxt  = pick_idx;
                  remain_nxt = hdr_len;
                  state_nxt  = ARB_BODY;
               end
            end
         end
         ARB_HDR: begin
            if (hs) begin
               if (hdr_len == '0) begin
                  prio_ptr_nxt = g_succ;
                  state_nxt    = ARB_IDLE;
               end else begin
                  remain_nxt = hdr_len;
                  state_nxt  = ARB_BODY;
               end
            end
         end
         ARB_BODY: begin
            if (hs) begin
               remain_nxt = remain_r - LEN_W'(1);
               if (remain_r == LEN_W'(1)) begin
                  prio_ptr_nxt = g_succ;
                  state_nxt    = ARB_IDLE;
               end
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ARB_IDLE;
         prio_ptr_r <= '0;
         owner_r    <= '0;
         remain_r   <= '0;
      end else begin
         state_r    <= state_nxt;
         prio_ptr_r <= prio_ptr_nxt;
         owner_r    <= owner_nxt;
         remain_r   <= remain_nxt;
      end
   end

endmodule
